// File: rtl/blake_seq_pkg.sv
// Shared types and constants for the BLAKE round/step sequencer.
// The width helper keeps index ports at least one bit wide for degenerate counts.
package blake_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } seq_state_e;

    localparam int BLAKE512_ROUNDS = 16;
    localparam int BLAKE256_ROUNDS = 14;
    localparam int DEFAULT_RDY_LAT = 64;

    function automatic int idx_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/blake_delay_line.sv
// Fixed-depth 1-bit shift register with synchronous clear; dout is din delayed
// by DEPTH cycles and any reports that at least one bit is still travelling.
module blake_delay_line #(
    parameter int DEPTH = 64
) (
    input  logic clk,
    input  logic rstb,
    input  logic clr,
    input  logic din,
    output logic dout,
    output logic any
);

    logic [DEPTH-1:0] shift_q;
    logic [DEPTH-1:0] shift_d;

    always_comb begin
        shift_d = '0;
        if (!clr) begin
            shift_d[0] = din;
            for (int i = 1; i < DEPTH; i++) begin
                shift_d[i] = shift_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            shift_q <= '0;
        end else begin
            shift_q <= shift_d;
        end
    end

    assign dout = shift_q[DEPTH-1];
    assign any  = |shift_q;

endmodule

// File: rtl/blake_round_sequencer.sv
// Step/round sequencer for the BLAKE compression cores: walks the G-steps of
// every round, flags the final step, and raises rdy a fixed latency later.
module blake_round_sequencer
    import blake_seq_pkg::*;
#(
    parameter int ROUNDS          = BLAKE512_ROUNDS,
    parameter int STEPS_PER_ROUND = 4,
    parameter int RDY_LAT         = DEFAULT_RDY_LAT,
    parameter int OVERLAP         = 0,
    localparam int SW = idx_width(STEPS_PER_ROUND),
    localparam int RW = idx_width(ROUNDS)
) (
    input  logic          clk,
    input  logic          rstb,
    input  logic          start,
    input  logic          stall,
    input  logic          abort,
    output logic          busy,
    output logic [SW-1:0] step_idx,
    output logic [RW-1:0] round_idx,
    output logic          last_step,
    output logic          last_round,
    output logic          count_done,
    output logic          rdy,
    output logic          inflight
);

    localparam logic [SW-1:0] STEP_LAST  = SW'(STEPS_PER_ROUND - 1);
    localparam logic [RW-1:0] ROUND_LAST = RW'(ROUNDS - 1);
    localparam bit            OVL        = (OVERLAP != 0);

    seq_state_e    state_q, state_d;
    logic [SW-1:0] step_q,  step_d;
    logic [RW-1:0] round_q, round_d;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= IDLE;
            step_q  <= '0;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            round_q <= round_d;
        end
    end

    // abort outranks everything; counters only move in RUN without stall
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        round_d = round_q;
        if (abort) begin
            state_d = IDLE;
            step_d  = '0;
            round_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    step_d  = '0;
                    round_d = '0;
                    if (start) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (count_done) begin
                        step_d  = '0;
                        round_d = '0;
                        state_d = (OVL && start) ? RUN : DRAIN;
                    end else if (!stall) begin
                        if (step_q == STEP_LAST) begin
                            step_d  = '0;
                            round_d = (round_q == ROUND_LAST) ? '0 : round_q + RW'(1);
                        end else begin
                            step_d  = step_q + SW'(1);
                        end
                    end
                end
                DRAIN: begin
                    step_d  = '0;
                    round_d = '0;
                    if (OVL && start) begin
                        state_d = RUN;
                    end else if (rdy) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    step_d  = '0;
                    round_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        busy       = (state_q != IDLE);
        step_idx   = step_q;
        round_idx  = round_q;
        last_step  = (state_q == RUN) && (step_q == STEP_LAST);
        last_round = (state_q == RUN) && (round_q == ROUND_LAST);
        count_done = last_step && last_round && !stall;
    end

    blake_delay_line #(
        .DEPTH(RDY_LAT)
    ) u_rdy_delay (
        .clk (clk),
        .rstb(rstb),
        .clr (abort),
        .din (count_done),
        .dout(rdy),
        .any (inflight)
    );

endmodule

// File: tb/tb_blake_round_sequencer.sv
// Scoreboard bench for blake_round_sequencer: three configurations share one
// stimulus path, a block-position/due-time model predicts every cycle's outputs.
module tb_blake_round_sequencer;

    typedef struct packed {
        logic       busy;
        logic [7:0] step;
        logic [7:0] round;
        logic       last_step;
        logic       last_round;
        logic       count_done;
        logic       rdy;
        logic       inflight;
    } obs_t;

    logic clk = 1'b0;
    logic rstb;
    logic start, stall, abort;
    int   sel;

    always #5 clk = ~clk;

    // per-instance gated inputs: only the selected configuration sees stimulus
    logic def_start, def_stall, def_abort;
    logic ovl_start, ovl_stall, ovl_abort;
    logic sml_start, sml_stall, sml_abort;

    assign def_start = (sel == 0) && start;
    assign def_stall = (sel == 0) && stall;
    assign def_abort = (sel == 0) && abort;
    assign ovl_start = (sel == 1) && start;
    assign ovl_stall = (sel == 1) && stall;
    assign ovl_abort = (sel == 1) && abort;
    assign sml_start = (sel == 2) && start;
    assign sml_stall = (sel == 2) && stall;
    assign sml_abort = (sel == 2) && abort;

    logic       def_busy, def_ls, def_lr, def_cd, def_rdy, def_inf;
    logic [1:0] def_step;
    logic [3:0] def_round;
    logic       ovl_busy, ovl_ls, ovl_lr, ovl_cd, ovl_rdy, ovl_inf;
    logic [1:0] ovl_step;
    logic [3:0] ovl_round;
    logic       sml_busy, sml_ls, sml_lr, sml_cd, sml_rdy, sml_inf;
    logic [0:0] sml_step;
    logic [3:0] sml_round;

    blake_round_sequencer u_def (
        .clk(clk), .rstb(rstb), .start(def_start), .stall(def_stall), .abort(def_abort),
        .busy(def_busy), .step_idx(def_step), .round_idx(def_round),
        .last_step(def_ls), .last_round(def_lr), .count_done(def_cd),
        .rdy(def_rdy), .inflight(def_inf)
    );

    blake_round_sequencer #(.OVERLAP(1)) u_ovl (
        .clk(clk), .rstb(rstb), .start(ovl_start), .stall(ovl_stall), .abort(ovl_abort),
        .busy(ovl_busy), .step_idx(ovl_step), .round_idx(ovl_round),
        .last_step(ovl_ls), .last_round(ovl_lr), .count_done(ovl_cd),
        .rdy(ovl_rdy), .inflight(ovl_inf)
    );

    blake_round_sequencer #(.ROUNDS(14), .STEPS_PER_ROUND(1), .RDY_LAT(1)) u_sml (
        .clk(clk), .rstb(rstb), .start(sml_start), .stall(sml_stall), .abort(sml_abort),
        .busy(sml_busy), .step_idx(sml_step), .round_idx(sml_round),
        .last_step(sml_ls), .last_round(sml_lr), .count_done(sml_cd),
        .rdy(sml_rdy), .inflight(sml_inf)
    );

    obs_t obs_def, obs_ovl, obs_sml, act_obs;

    assign obs_def = {def_busy, 6'd0, def_step, 4'd0, def_round, def_ls, def_lr, def_cd, def_rdy, def_inf};
    assign obs_ovl = {ovl_busy, 6'd0, ovl_step, 4'd0, ovl_round, ovl_ls, ovl_lr, ovl_cd, ovl_rdy, ovl_inf};
    assign obs_sml = {sml_busy, 7'd0, sml_step, 4'd0, sml_round, sml_ls, sml_lr, sml_cd, sml_rdy, sml_inf};
    assign act_obs = (sel == 0) ? obs_def : (sel == 1) ? obs_ovl : obs_sml;

    int total = 0;
    int bad   = 0;
    obs_t exp_q[$];

    // reference model: block position plus absolute cycles at which rdy is due
    int m_cyc   = 0;
    int m_state = 0;
    int m_pos   = 0;
    int m_due[$];
    int m_r, m_s, m_l;
    bit m_ov;

    task automatic checkOutput(input obs_t want, input obs_t got, input string tag);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s t=%0t got busy=%0b step=%0d round=%0d ls=%0b lr=%0b cd=%0b rdy=%0b inf=%0b want busy=%0b step=%0d round=%0d ls=%0b lr=%0b cd=%0b rdy=%0b inf=%0b",
                     tag, $time, got.busy, got.step, got.round, got.last_step, got.last_round,
                     got.count_done, got.rdy, got.inflight, want.busy, want.step, want.round,
                     want.last_step, want.last_round, want.count_done, want.rdy, want.inflight);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic st, input logic ab);
        obs_t e;
        logic in_run, cd, r;
        @(posedge clk);
        #1;
        start = s;
        stall = st;
        abort = ab;
        in_run = (m_state == 1);
        cd = in_run && (m_pos == m_r * m_s - 1) && !st;
        r  = (m_due.size() > 0) && (m_due[0] == m_cyc);
        e.busy       = (m_state != 0);
        e.step       = 8'(m_pos % m_s);
        e.round      = 8'(m_pos / m_s);
        e.last_step  = in_run && ((m_pos % m_s) == m_s - 1);
        e.last_round = in_run && ((m_pos / m_s) == m_r - 1);
        e.count_done = cd;
        e.rdy        = r;
        e.inflight   = (m_due.size() > 0);
        exp_q.push_back(e);
        if (ab) begin
            m_due.delete();
            m_state = 0;
            m_pos   = 0;
        end else begin
            if (r) void'(m_due.pop_front());
            if (cd) m_due.push_back(m_cyc + m_l);
            case (m_state)
                0: if (s) begin m_state = 1; m_pos = 0; end
                1: begin
                    if (cd) begin
                        m_pos   = 0;
                        m_state = (m_ov && s) ? 1 : 2;
                    end else if (!st) begin
                        m_pos++;
                    end
                end
                default: begin
                    if (m_ov && s) m_state = 1;
                    else if (r)    m_state = 0;
                end
            endcase
        end
        m_cyc++;
    endtask

    task automatic idleCycles(input int n, input logic s);
        for (int i = 0; i < n; i++) applyStimulus(s, 1'b0, 1'b0);
    endtask

    task automatic randomPhase(input int n, input int start_pct, input int stall_pct, input int abort_pm);
        for (int i = 0; i < n; i++) begin
            applyStimulus($urandom_range(99) < start_pct,
                          $urandom_range(99) < stall_pct,
                          $urandom_range(999) < abort_pm);
        end
    endtask

    // asynchronous reset between clock edges, then switch to configuration new_sel
    task automatic doAsyncReset(input int new_sel);
        @(posedge clk);
        #1;
        start = 1'b0;
        stall = 1'b0;
        abort = 1'b0;
        #2;
        rstb = 1'b0;
        #1;
        checkOutput('0, obs_def, "async_reset_def");
        checkOutput('0, obs_ovl, "async_reset_ovl");
        checkOutput('0, obs_sml, "async_reset_sml");
        @(posedge clk);
        #1;
        rstb = 1'b1;
        sel  = new_sel;
        m_r  = (new_sel == 2) ? 14 : 16;
        m_s  = (new_sel == 2) ? 1 : 4;
        m_l  = (new_sel == 2) ? 1 : 64;
        m_ov = (new_sel == 1);
        m_state = 0;
        m_pos   = 0;
        m_due.delete();
    endtask

    // monitor: one expected record is popped per cycle, compared mid-cycle
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) checkOutput(exp_q.pop_front(), act_obs, "cycle");
        end
    end

    initial begin
        rstb  = 1'b0;
        start = 1'b0;
        stall = 1'b0;
        abort = 1'b0;
        sel   = 0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput('0, obs_def, "reset_def");
        checkOutput('0, obs_ovl, "reset_ovl");
        checkOutput('0, obs_sml, "reset_sml");
        doAsyncReset(0);

        $display("[TB] single block, default configuration");
        applyStimulus(1'b1, 1'b0, 1'b0);
        idleCycles(140, 1'b0);

        $display("[TB] stall at step 2 round 7");
        applyStimulus(1'b1, 1'b0, 1'b0);
        idleCycles(30, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0);
        idleCycles(140, 1'b0);

        $display("[TB] abort during drain");
        applyStimulus(1'b1, 1'b0, 1'b0);
        idleCycles(64, 1'b0);
        idleCycles(10, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        idleCycles(200, 1'b0);

        $display("[TB] start ignored in run and drain");
        applyStimulus(1'b1, 1'b0, 1'b0);
        idleCycles(20, 1'b0);
        idleCycles(20, 1'b1);
        idleCycles(24, 1'b0);
        idleCycles(30, 1'b1);
        idleCycles(100, 1'b0);

        $display("[TB] random, default configuration");
        randomPhase(2500, 10, 15, 3);

        doAsyncReset(1);
        $display("[TB] overlap with start held high");
        idleCycles(64 * 4 + 1, 1'b1);
        idleCycles(140, 1'b0);
        $display("[TB] random, overlap configuration");
        randomPhase(2500, 40, 15, 3);

        doAsyncReset(2);
        $display("[TB] 14 rounds, 1 step, latency 1");
        applyStimulus(1'b1, 1'b0, 1'b0);
        idleCycles(20, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        idleCycles(5, 1'b0);
        doAsyncReset(2);
        $display("[TB] random, small configuration");
        randomPhase(1500, 20, 15, 5);

        @(negedge clk);
        @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_drain got=%0d want=0 leftover entries", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
